// File: rtl/radio_enable_sequencer.sv
// -----------------------------------------------------------------------------
// radio_enable_sequencer
//
// M1-side source of the radio-enable handshake across the isolated M1/M2
// boundary. The asynchronous request is synchronized (2 flops) and debounced.
// The filtered request then drives a small FSM. That FSM raises
// radioEnableSynced toward M2 and waits for the registered radioEnable coming
// back (radioEnableFb) as an acknowledge, with timeout detection. While
// isolateM1M2 is high the boundary is clamped and every output is 0.
//
// Ports
//   ck                 clock, rising edge
//   arst               asynchronous reset, active-high
//   isolateM1M2        isolation control; high = M1/M2 boundary clamped
//   radioEnableReq     asynchronous enable request (software/PMU)
//   radioEnableFb      registered radioEnable returned from M2 (same clock)
//   clrErr             single-cycle pulse, clears the error state
//   radioEnableSynced  enable toward M2, registered
//   radioOn            high only while the handshake is complete (ON)
//   busy               high while arming or disarming
//   timeoutErr         high in the error state
//
// Parameters
//   DEBOUNCE  consecutive mismatching cycles before the filter flips (1..255)
//   TIMEOUT   cycles allowed for the acknowledge to match (2..65535)
//   CNT_W     timer width, 2**CNT_W must exceed TIMEOUT
// -----------------------------------------------------------------------------
module radio_enable_sequencer #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 16
) (
  input  logic ck,
  input  logic arst,
  input  logic isolateM1M2,
  input  logic radioEnableReq,
  input  logic radioEnableFb,
  input  logic clrErr,
  output logic radioEnableSynced,
  output logic radioOn,
  output logic busy,
  output logic timeoutErr
);

  localparam int DCNT_W = 8;
  localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]  TIMER_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMING,
    S_ON,
    S_DISARM,
    S_ERR,
    S_ISO
  } state_t;

  // Synchronizer chain; req_s_q is the metastability-safe request.
  logic sync1_q;
  logic req_s_q;

  // Debounce filter.
  logic              req_f_q, req_f_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;

  // FSM, timer and registered outputs.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             synced_q, synced_d;
  logic             radio_on_q, radio_on_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;

  logic timer_expired;

  always_comb begin
    // Debounce: count consecutive cycles of disagreement. The flip happens on
    // the DEBOUNCE-th such cycle, so shorter glitches never reach req_f.
    req_f_d = req_f_q;
    dcnt_d  = '0;
    if (req_s_q != req_f_q) begin
      if (dcnt_q == DCNT_LAST) begin
        req_f_d = req_s_q;
        dcnt_d  = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end

    timer_expired = (timer_q == TIMER_LAST);

    // Next state. Isolation overrides everything; inside each state the
    // transitions are tested in priority order (e.g. an acknowledge in
    // ARMING wins over a simultaneous timeout).
    state_d = state_q;
    if (isolateM1M2) begin
      state_d = S_ISO;
    end else begin
      unique case (state_q)
        S_IDLE:   if (req_f_q) state_d = S_ARMING;
        S_ARMING: begin
          if (radioEnableFb)      state_d = S_ON;
          else if (!req_f_q)      state_d = S_DISARM;
          else if (timer_expired) state_d = S_ERR;
        end
        S_ON: begin
          if (!req_f_q)            state_d = S_DISARM;
          else if (!radioEnableFb) state_d = S_ERR;
        end
        S_DISARM: begin
          if (!radioEnableFb)     state_d = S_IDLE;
          else if (timer_expired) state_d = S_ERR;
        end
        S_ERR:    if (clrErr && !req_f_q) state_d = S_IDLE;
        S_ISO:    state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    // Timer restarts on every state change and only runs while waiting for
    // the acknowledge; it saturates instead of wrapping.
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if ((state_q == S_ARMING || state_q == S_DISARM) && (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register, glitch-free.
    synced_d      = (state_d == S_ARMING) || (state_d == S_ON);
    radio_on_d    = (state_d == S_ON);
    busy_d        = (state_d == S_ARMING) || (state_d == S_DISARM);
    timeout_err_d = (state_d == S_ERR);
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      sync1_q       <= 1'b0;
      req_s_q       <= 1'b0;
      req_f_q       <= 1'b0;
      dcnt_q        <= '0;
      state_q       <= S_IDLE;
      timer_q       <= '0;
      synced_q      <= 1'b0;
      radio_on_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      sync1_q       <= radioEnableReq;
      req_s_q       <= sync1_q;
      req_f_q       <= req_f_d;
      dcnt_q        <= dcnt_d;
      state_q       <= state_d;
      timer_q       <= timer_d;
      synced_q      <= synced_d;
      radio_on_q    <= radio_on_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign radioEnableSynced = synced_q;
  assign radioOn           = radio_on_q;
  assign busy              = busy_q;
  assign timeoutErr        = timeout_err_q;

endmodule

// File: tb/tb_radio_enable_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for radio_enable_sequencer. Directed scenarios check fixed
// expectations. A long randomized run is compared cycle by cycle against a
// behavioural model of the handshake rules.
// Output vector order in checks: {synced, radioOn, busy, timeoutErr}.
// -----------------------------------------------------------------------------
module tb_radio_enable_sequencer;

  localparam int DEBOUNCE = 4;
  localparam int TIMEOUT  = 16;

  logic ck = 1'b0;
  logic arst;
  logic iso;
  logic req;
  logic fb;
  logic clr;
  logic radioEnableSynced;
  logic radioOn;
  logic busy;
  logic timeoutErr;

  int checks   = 0;
  int failures = 0;

  // When set, the bench plays the M2 register: fb presented at an edge equals
  // the synced value expected after the previous edge.
  bit m2_follow = 1'b0;

  always #5 ck = ~ck;

  radio_enable_sequencer #(
    .DEBOUNCE(DEBOUNCE),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (16)
  ) dut (
    .ck               (ck),
    .arst             (arst),
    .isolateM1M2      (iso),
    .radioEnableReq   (req),
    .radioEnableFb    (fb),
    .clrErr           (clr),
    .radioEnableSynced(radioEnableSynced),
    .radioOn          (radioOn),
    .busy             (busy),
    .timeoutErr       (timeoutErr)
  );

  // ---------------- behavioural reference model ----------------
  typedef enum int {P_IDLE, P_ARMING, P_ON, P_DISARM, P_ERR, P_ISO} phase_t;

  bit     m_s1, m_s2, m_rf;
  int     m_run;       // consecutive cycles filtered value disagreed
  phase_t m_phase;
  int     m_age;       // cycles spent in the current phase

  function automatic void mdl_reset();
    m_s1 = 0; m_s2 = 0; m_rf = 0; m_run = 0;
    m_phase = P_IDLE; m_age = 0;
  endfunction

  function automatic logic [3:0] mdl_outs();
    logic s, o, b, e;
    s = (m_phase == P_ARMING) || (m_phase == P_ON);
    o = (m_phase == P_ON);
    b = (m_phase == P_ARMING) || (m_phase == P_DISARM);
    e = (m_phase == P_ERR);
    return {s, o, b, e};
  endfunction

  // One clock edge worth of the rules, using the inputs present at the edge.
  function automatic void mdl_update(bit r, bit f, bit i, bit c);
    bit     rf_now;
    bit     last_cycle;
    phase_t nxt;
    rf_now     = m_rf;
    last_cycle = (m_age + 1 == TIMEOUT);
    nxt        = m_phase;
    if (i) nxt = P_ISO;
    else begin
      case (m_phase)
        P_IDLE:   if (rf_now) nxt = P_ARMING;
        P_ARMING: if (f) nxt = P_ON; else if (!rf_now) nxt = P_DISARM;
                  else if (last_cycle) nxt = P_ERR;
        P_ON:     if (!rf_now) nxt = P_DISARM; else if (!f) nxt = P_ERR;
        P_DISARM: if (!f) nxt = P_IDLE; else if (last_cycle) nxt = P_ERR;
        P_ERR:    if (c && !rf_now) nxt = P_IDLE;
        default:  nxt = P_IDLE;
      endcase
    end
    m_age   = (nxt != m_phase) ? 0 : m_age + 1;
    m_phase = nxt;
    if (m_s2 != m_rf) begin
      m_run++;
      if (m_run == DEBOUNCE) begin
        m_rf  = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = r;
  endfunction

  function automatic logic [3:0] dut_outs();
    return {radioEnableSynced, radioOn, busy, timeoutErr};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge ck);
    mdl_update(req, fb, iso, clr);
    #1;
    if (m2_follow) fb = mdl_outs()[3];
  endtask

  task automatic do_reset();
    arst = 1'b1;
    mdl_reset();
    repeat (2) @(posedge ck);
    #1;
    arst = 1'b0;
  endtask

  task automatic quiet_reset();
    req = 0; fb = 0; iso = 0; clr = 0; m2_follow = 0;
    do_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n;
    arst = 1'b1; req = 1; fb = 1; iso = 0; clr = 0; m2_follow = 0;
    mdl_reset();
    #3;
    checks++;
    if (dut_outs() !== 4'b0000) begin
      failures++;
      $display("FAIL reset_async outs=%b expected=%b", dut_outs(), 4'b0000);
    end
    repeat (3) @(posedge ck);
    #1;
    checks++;
    if (dut_outs() !== 4'b0000) begin
      failures++;
      $display("FAIL reset_held outs=%b expected=%b", dut_outs(), 4'b0000);
    end
    arst = 1'b0;
    n = 0;
    while (radioEnableSynced !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    // The first edge after release is the first request sample.
    checks++;
    if (n - 1 != DEBOUNCE + 2) begin
      failures++;
      $display("FAIL reset_latency edges_after_sample=%0d expected=%0d", n - 1, DEBOUNCE + 2);
    end
    $display("test_reset: synced rose %0d edges after first sample", n - 1);
  endtask

  task automatic test_normal();
    int n;
    quiet_reset();
    m2_follow = 1; req = 1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (dut_outs() !== 4'b1010) begin
      failures++;
      $display("FAIL normal_arming outs=%b expected=%b", dut_outs(), 4'b1010);
    end
    step();
    checks++;
    if (dut_outs() !== 4'b1100) begin
      failures++;
      $display("FAIL normal_on outs=%b expected=%b", dut_outs(), 4'b1100);
    end
    repeat (5) step();
    checks++;
    if (dut_outs() !== 4'b1100) begin
      failures++;
      $display("FAIL normal_hold outs=%b expected=%b", dut_outs(), 4'b1100);
    end
    req = 0;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (dut_outs() !== 4'b0010) begin
      failures++;
      $display("FAIL normal_disarm outs=%b expected=%b", dut_outs(), 4'b0010);
    end
    step();
    checks++;
    if (dut_outs() !== 4'b0000) begin
      failures++;
      $display("FAIL normal_idle outs=%b expected=%b", dut_outs(), 4'b0000);
    end
    $display("test_normal: arm/on/disarm/idle sequence done");
  endtask

  task automatic test_glitch();
    bit seen;
    quiet_reset();
    seen = 0;
    req = 1; repeat (DEBOUNCE - 1) step();
    req = 0;
    repeat (12) begin step(); seen |= radioEnableSynced; end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL glitch_short synced_seen=%b expected=%b", seen, 1'b0);
    end
    seen = 0;
    req = 1; repeat (DEBOUNCE) step();
    req = 0;
    repeat (12) begin step(); seen |= radioEnableSynced; end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL glitch_long synced_seen=%b expected=%b", seen, 1'b1);
    end
    $display("test_glitch: short pulse filtered, long pulse passed");
  endtask

  task automatic test_timeout();
    int n;
    int k;
    quiet_reset();
    req = 1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin step(); n++; end
    k = 0;
    while (timeoutErr !== 1'b1 && k < 40) begin step(); k++; end
    checks++;
    if (k != TIMEOUT) begin
      failures++;
      $display("FAIL timeout_len arming_cycles=%0d expected=%0d", k, TIMEOUT);
    end
    checks++;
    if (dut_outs() !== 4'b0001) begin
      failures++;
      $display("FAIL timeout_err outs=%b expected=%b", dut_outs(), 4'b0001);
    end
    clr = 1; step(); clr = 0; step();
    checks++;
    if (dut_outs() !== 4'b0001) begin
      failures++;
      $display("FAIL timeout_clr_ignored outs=%b expected=%b", dut_outs(), 4'b0001);
    end
    req = 0;
    repeat (DEBOUNCE + 3) step();
    checks++;
    if (dut_outs() !== 4'b0001) begin
      failures++;
      $display("FAIL timeout_sticky outs=%b expected=%b", dut_outs(), 4'b0001);
    end
    clr = 1; step(); clr = 0;
    checks++;
    if (dut_outs() !== 4'b0000) begin
      failures++;
      $display("FAIL timeout_cleared outs=%b expected=%b", dut_outs(), 4'b0000);
    end
    $display("test_timeout: error after %0d arming cycles, cleared", k);
  endtask

  task automatic test_drop();
    int n;
    quiet_reset();
    m2_follow = 1; req = 1;
    n = 0;
    while (radioOn !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (dut_outs() !== 4'b1100) begin
      failures++;
      $display("FAIL drop_on outs=%b expected=%b", dut_outs(), 4'b1100);
    end
    m2_follow = 0; fb = 0;
    step();
    checks++;
    if (dut_outs() !== 4'b0001) begin
      failures++;
      $display("FAIL drop_err outs=%b expected=%b", dut_outs(), 4'b0001);
    end
    $display("test_drop: acknowledge drop in ON raised error");
  endtask

  task automatic test_isolation();
    int n;
    int bad;
    quiet_reset();
    req = 1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin step(); n++; end
    iso = 1; fb = 1;
    step();
    checks++;
    if (dut_outs() !== 4'b0000) begin
      failures++;
      $display("FAIL iso_enter outs=%b expected=%b", dut_outs(), 4'b0000);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      fb = 1'($urandom_range(0, 1));
      step();
      if (dut_outs() !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL iso_clamped nonzero_cycles=%0d expected=0", bad);
    end
    fb = 0; iso = 0; m2_follow = 1;
    step();
    checks++;
    if (dut_outs() !== 4'b0000) begin
      failures++;
      $display("FAIL iso_release_idle outs=%b expected=%b", dut_outs(), 4'b0000);
    end
    step();
    checks++;
    if (dut_outs() !== 4'b1010) begin
      failures++;
      $display("FAIL iso_rearm outs=%b expected=%b", dut_outs(), 4'b1010);
    end
    step();
    checks++;
    if (dut_outs() !== 4'b1100) begin
      failures++;
      $display("FAIL iso_on outs=%b expected=%b", dut_outs(), 4'b1100);
    end
    $display("test_isolation: clamped 50 cycles, re-armed after release");
  endtask

  task automatic test_async_reset();
    int n;
    quiet_reset();
    m2_follow = 1; req = 1;
    n = 0;
    while (radioOn !== 1'b1 && n < 20) begin step(); n++; end
    #2;
    arst = 1'b1;
    #1;
    checks++;
    if (dut_outs() !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset outs=%b expected=%b", dut_outs(), 4'b0000);
    end
    m2_follow = 0; req = 0; fb = 0;
    do_reset();
    $display("test_async_reset: mid-ON reset cleared outputs immediately");
  endtask

  task automatic test_random();
    int iso_left;
    int cyc_fail;
    quiet_reset();
    iso_left = 0;
    cyc_fail = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 11) == 0) req = ~req;
      if (cyc % 100 == 0) m2_follow = ($urandom_range(0, 3) != 0);
      if (!m2_follow && $urandom_range(0, 3) == 0) fb = ~fb;
      else if (m2_follow && $urandom_range(0, 39) == 0) fb = ~fb;
      if (iso_left > 0) iso_left--;
      else if ($urandom_range(0, 149) == 0) iso_left = int'($urandom_range(5, 40));
      iso = (iso_left > 0);
      clr = ($urandom_range(0, 9) == 0);
      step();
      clr = 0;
      checks++;
      if (dut_outs() !== mdl_outs()) begin
        failures++;
        cyc_fail++;
        $display("FAIL random cycle=%0d outs=%b expected=%b", cyc, dut_outs(), mdl_outs());
      end
    end
    iso = 0;
    $display("test_random: 3000 cycles compared, %0d differences", cyc_fail);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_glitch();
    test_timeout();
    test_drop();
    test_isolation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/radio_enable_sequencer.md
Name: radio_enable_sequencer

Overview:
M1-side source of the radio-enable handshake across the isolated M1/M2 boundary.
- Synchronizes and debounces an asynchronous radio-enable request.
- Drives radioEnableSynced to the M2 register stage.
- Checks the registered radioEnable returned from M2 as an acknowledge, with timeout detection.
- Forces a safe 0 on its output while isolateM1M2 is asserted.

Parameters:
DEBOUNCE, 4, consecutive cycles the synchronized request must differ from the filtered value before the filtered value flips; legal range 1..255.
TIMEOUT, 16, cycles allowed in ARMING/DISARM for the acknowledge to match; legal range 2..65535.
CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
ck  input  1  clock, rising edge
arst  input  1  asynchronous reset, active-high
isolateM1M2  input  1  isolation control; high = M1/M2 boundary clamped
radioEnableReq  input  1  asynchronous enable request from software/PMU
radioEnableFb  input  1  registered radioEnable returned from M2 (acknowledge)
clrErr  input  1  single-cycle pulse, clears ERR
radioEnableSynced  output  1  enable toward M2, registered
radioOn  output  1  high only in ON
busy  output  1  high in ARMING or DISARM
timeoutErr  output  1  high in ERR

Behaviour:
- Reset: arst high asynchronously clears everything.
  - sync flops, req_f, debounce counter and timer = 0; state = IDLE.
  - All outputs = 0.
- Synchronizer: 2-flop chain on radioEnableReq, giving req_s.
- radioEnableFb is a registered M2 output on the same ck and is not synchronized.
- Debounce:
  - When req_s != req_f, dcnt increments each cycle.
  - When req_s == req_f, dcnt is cleared.
  - When dcnt == DEBOUNCE-1 and req_s != req_f, req_f <= req_s and dcnt <= 0.
  - Glitches shorter than DEBOUNCE cycles at req_s are filtered.
- Latency: request sampled high at edge N gives req_f high after edge N+1+DEBOUNCE, and radioEnableSynced high after edge N+2+DEBOUNCE (N+6 for DEBOUNCE=4).
- All outputs are registered and decoded from the state register.
- FSM states, outputs and transitions:
  - IDLE: synced=0. req_f=1 -> ARMING, timer cleared.
  - ARMING: synced=1, busy=1, timer increments.
    - fb=1 -> ON.
    - else req_f=0 -> DISARM, timer cleared.
    - else timer==TIMEOUT-1 -> ERR.
  - ON: synced=1, radioOn=1.
    - req_f=0 -> DISARM, timer cleared.
    - else fb=0 -> ERR (unexpected drop).
  - DISARM: synced=0, busy=1, timer increments.
    - fb=0 -> IDLE.
    - else timer==TIMEOUT-1 -> ERR.
  - ERR: synced=0, timeoutErr=1. clrErr=1 and req_f=0 -> IDLE. clrErr while req_f=1 is ignored.
  - ISO: all outputs 0.
- Priority (highest first): isolateM1M2, then the listed transitions in order. In ARMING, fb=1 wins over a simultaneous timeout.
- Isolation:
  - isolateM1M2=1 in any state -> ISO on the next edge; synced=0 from that edge.
  - While in ISO, timer is cleared and fb is ignored.
  - isolateM1M2=0 in ISO -> IDLE. If req_f is still 1, the FSM re-arms normally from IDLE.
  - The synchronizer and debounce keep running during ISO.
- Timer: saturates (no wrap) and is cleared on every state entry.
- Reset mid-operation: arst in any state forces synced=0 immediately (asynchronously); no partial handshake resumes.

Test Plan:
- Reset and power-up:
  - Stimulus: arst=1, req=1, fb=1.
  - Required: all outputs 0. After arst release, synced rises exactly DEBOUNCE+2 edges after the first req sample (edge 6 for DEBOUNCE=4).
- Normal on/off:
  - Stimulus: req=1; fb follows synced one cycle later (M2 model).
  - Required: ARMING lasts 1 cycle, then radioOn=1.
  - Stimulus: req=0.
  - Required: DISARM 1 cycle, then IDLE with synced=0, busy=0.
- Glitch filter: 3-cycle high pulse on req_s with DEBOUNCE=4 -> req_f and synced stay 0. A 4-cycle pulse -> synced=1.
- Timeout:
  - fb held 0 in ARMING -> timeoutErr=1 after exactly TIMEOUT=16 ARMING cycles, synced=0.
  - clrErr while req=1 -> stays ERR.
  - req=0, then clrErr -> IDLE.
- Unexpected drop: in ON, force fb=0 for 1 cycle -> ERR next edge, radioOn=0.
- Isolation mid-handshake:
  - isolateM1M2=1 during ARMING with fb toggling -> synced=0 next edge; no ERR during 50 isolated cycles.
  - Release isolation with req=1 -> IDLE, ARMING, ON sequence.
